// File: rtl/rf80386_pkg.sv
// Shared rf80386 bus definitions: cycle-type codes, responder state encoding, idle data value.
package rf80386_pkg;

    localparam logic [2:0] CT_PASSIVE = 3'd0;
    localparam logic [2:0] CT_INTA    = 3'd1;
    localparam logic [2:0] CT_RDIO    = 3'd2;
    localparam logic [2:0] CT_WRIO    = 3'd3;
    localparam logic [2:0] CT_CODE    = 3'd4;
    localparam logic [2:0] CT_HALT    = 3'd5;
    localparam logic [2:0] CT_RDMEM   = 3'd6;
    localparam logic [2:0] CT_WRMEM   = 3'd7;

    localparam logic [7:0] DATA_INACTIVE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        MEM_WR,
        IO,
        ACK,
        HOLD
    } e_wbresp_state;

endpackage

// File: rtl/rf80386_wb_responder.sv
// Wishbone classic responder steering rf80386 cycles to SRAM, I/O, INTA and HALT; RF80386_WB_ERR_EN turns out-of-window accesses into err_o.
// Latency from request sample: SRAM read 2+RD_LAT, SRAM write 2, INTA/HALT 1, I/O one cycle after io_ack_i.
// Backpressure: one transfer in flight; after ack the responder holds until stb_i drops, I/O waits on io_ack_i.
module rf80386_wb_responder
    import rf80386_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] MEM_BASE = 32'h0000_0000,
    parameter logic [AW-1:0] MEM_SIZE = 32'h0010_0000,
    parameter int            RD_LAT   = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic          lock_i,
    input  logic [2:0]    cyc_type_i,
    input  logic [AW-1:0] adr_i,
    input  logic [7:0]    dat_i,
    output logic [7:0]    dat_o,
    output logic          ack_o,
    output logic          err_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [7:0]    mem_dat_o,
    input  logic [7:0]    mem_dat_i,
    output logic          io_stb_o,
    output logic          io_we_o,
    output logic [15:0]   io_adr_o,
    output logic [7:0]    io_dat_o,
    input  logic [7:0]    io_dat_i,
    input  logic          io_ack_i,
    input  logic [7:0]    int_vect_i,
    output logic          inta_o,
    output logic          halted_o,
    output logic          locked_o
);

    localparam logic [1:0] RD_CNT = 2'(RD_LAT);

    e_wbresp_state state, state_n;
    logic [1:0]    cnt, cnt_n;
    logic [7:0]    dat_n, mem_dat_n, io_dat_n;
    logic [AW-1:0] mem_adr_n, offset;
    logic [15:0]   io_adr_n;
    logic          ack_n, mem_ce_n, mem_we_n, io_stb_n, io_we_n, inta_n, halted_n, locked_n;
    logic          req, accept, in_win;
`ifdef RF80386_WB_ERR_EN
    logic          err_n;
`endif

    // Unsigned subtract makes addresses below the base wrap high and fall outside the window.
    assign offset = adr_i - MEM_BASE;
    assign in_win = offset < MEM_SIZE;
    assign req    = cyc_i && stb_i;
    assign accept = (state == IDLE) && req && (cyc_type_i != CT_PASSIVE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dat_n     = dat_o;
        ack_n     = 1'b0;
        mem_ce_n  = 1'b0;
        mem_we_n  = 1'b0;
        mem_adr_n = mem_adr_o;
        mem_dat_n = mem_dat_o;
        io_stb_n  = 1'b0;
        io_we_n   = io_we_o;
        io_adr_n  = io_adr_o;
        io_dat_n  = io_dat_o;
        inta_n    = 1'b0;
        halted_n  = halted_o;
        locked_n  = locked_o;
`ifdef RF80386_WB_ERR_EN
        err_n     = 1'b0;
`endif
        if ((state == IDLE || state == HOLD) && !lock_i) locked_n = 1'b0;
        if (accept) begin
            halted_n = (cyc_type_i == CT_HALT);
            if (lock_i) locked_n = 1'b1;
        end

        case (state)
            IDLE: if (req) begin
                case (cyc_type_i)
                    CT_CODE, CT_RDMEM: begin
                        if (in_win) begin
                            state_n   = MEM_RD;
                            mem_ce_n  = 1'b1;
                            mem_adr_n = offset;
                            cnt_n     = RD_CNT;
                        end else begin
                            state_n = ACK;
`ifdef RF80386_WB_ERR_EN
                            err_n   = 1'b1;
`else
                            ack_n   = 1'b1;
                            dat_n   = DATA_INACTIVE;
`endif
                        end
                    end
                    CT_WRMEM: begin
                        if (in_win) begin
                            state_n   = MEM_WR;
                            mem_ce_n  = 1'b1;
                            mem_we_n  = 1'b1;
                            mem_adr_n = offset;
                            mem_dat_n = dat_i;
                        end else begin
                            state_n = ACK;
`ifdef RF80386_WB_ERR_EN
                            err_n   = 1'b1;
`else
                            ack_n   = 1'b1;
`endif
                        end
                    end
                    CT_RDIO, CT_WRIO: begin
                        state_n  = IO;
                        io_stb_n = 1'b1;
                        io_we_n  = (cyc_type_i == CT_WRIO);
                        io_adr_n = adr_i[15:0];
                        io_dat_n = dat_i;
                    end
                    CT_INTA: begin
                        state_n = ACK;
                        ack_n   = 1'b1;
                        inta_n  = 1'b1;
                        dat_n   = int_vect_i;
                    end
                    CT_HALT: begin
                        state_n = ACK;
                        ack_n   = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM_RD: begin
                if (!cyc_i) begin
                    state_n = IDLE;
                end else if (cnt == 2'd0) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                    dat_n   = mem_dat_i;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            MEM_WR: begin
                // The SRAM write has already been issued; an abort only suppresses the ack.
                if (!cyc_i) begin
                    state_n = IDLE;
                end else begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                end
            end
            IO: begin
                if (!cyc_i) begin
                    state_n = IDLE;
                end else if (io_ack_i) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                    if (!io_we_o) dat_n = io_dat_i;
                end else begin
                    io_stb_n = 1'b1;
                end
            end
            ACK:  state_n = HOLD;
            HOLD: if (!stb_i || !cyc_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            dat_o     <= DATA_INACTIVE;
            ack_o     <= 1'b0;
            mem_ce_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_adr_o <= '0;
            mem_dat_o <= 8'h00;
            io_stb_o  <= 1'b0;
            io_we_o   <= 1'b0;
            io_adr_o  <= 16'h0000;
            io_dat_o  <= 8'h00;
            inta_o    <= 1'b0;
            halted_o  <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dat_o     <= dat_n;
            ack_o     <= ack_n;
            mem_ce_o  <= mem_ce_n;
            mem_we_o  <= mem_we_n;
            mem_adr_o <= mem_adr_n;
            mem_dat_o <= mem_dat_n;
            io_stb_o  <= io_stb_n;
            io_we_o   <= io_we_n;
            io_adr_o  <= io_adr_n;
            io_dat_o  <= io_dat_n;
            inta_o    <= inta_n;
            halted_o  <= halted_n;
            locked_o  <= locked_n;
        end
    end

`ifdef RF80386_WB_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_o <= 1'b0;
        else         err_o <= err_n;
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf80386_wb_responder.sv
// Scoreboard bench for rf80386_wb_responder with RD_LAT=2 and a non-zero SRAM window base.
module tb_rf80386_wb_responder;
    import rf80386_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0010_0000;
`ifdef RF80386_WB_ERR_EN
    localparam logic       OOW_ERR = 1'b1;
    localparam logic [7:0] OOW_DAT = 8'h77;
`else
    localparam logic       OOW_ERR = 1'b0;
    localparam logic [7:0] OOW_DAT = 8'hFF;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
    logic [2:0]  cyc_type = CT_PASSIVE;
    logic [31:0] adr = '0;
    logic [7:0]  wdat = 8'h00, io_dat_i = 8'h00, int_vect = 8'h00;
    logic        io_ack_i = 1'b0;
    logic [7:0]  dat_o, mem_dat_o, mem_dat_i, io_dat_o;
    logic        ack_o, err_o, mem_ce_o, mem_we_o, io_stb_o, io_we_o, inta_o, halted_o, locked_o;
    logic [31:0] mem_adr_o;
    logic [15:0] io_adr_o;

    always #5 clk = ~clk;

    rf80386_wb_responder #(.AW(32), .MEM_BASE(BASE), .MEM_SIZE(SIZE), .RD_LAT(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .lock_i(lock),
        .cyc_type_i(cyc_type), .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .ack_o(ack_o),
        .err_o(err_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .io_stb_o(io_stb_o), .io_we_o(io_we_o),
        .io_adr_o(io_adr_o), .io_dat_o(io_dat_o), .io_dat_i(io_dat_i), .io_ack_i(io_ack_i),
        .int_vect_i(int_vect), .inta_o(inta_o), .halted_o(halted_o), .locked_o(locked_o)
    );

    // Small SRAM: address latched on a read strobe, data follows from that point on.
    logic [7:0] sram [16];
    logic [3:0] rd_adr;
    always @(posedge clk) begin
        if (!rst_n) begin
            sram[5]  <= 8'hA5;
            sram[15] <= 8'h77;
            rd_adr   <= 4'd0;
        end else if (mem_ce_o) begin
            if (mem_we_o) sram[mem_adr_o[3:0]] <= mem_dat_o;
            else          rd_adr <= mem_adr_o[3:0];
        end
    end
    assign mem_dat_i = sram[rd_adr];

    typedef struct {
        string      name;
        logic [7:0] dat;
        logic       chk_dat;
        logic       err;
        int         due;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0;
    int cyc_cnt = 0;
    int ce_cnt = 0, we_cnt = 0, io_cnt = 0, inta_cnt = 0, ack_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ack/err and checks cycle, flags and data.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (mem_ce_o) ce_cnt++;
            if (mem_we_o) we_cnt++;
            if (io_stb_o) io_cnt++;
            if (inta_o)   inta_cnt++;
            if (ack_o || err_o) begin
                ack_cnt++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: ack=%0b err=%0b with no transfer pending", ack_o, err_o);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_cycle"}, cyc_cnt, e.due);
                    check({e.name, "_err"}, {31'd0, err_o}, {31'd0, e.err});
                    check({e.name, "_ack"}, {31'd0, ack_o}, {31'd0, !e.err});
                    if (e.chk_dat) check({e.name, "_dat"}, {24'd0, dat_o}, {24'd0, e.dat});
                end
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] ct, input logic [31:0] a_adr,
                         input logic [7:0] a_dat, input logic a_lock, input logic push,
                         input int lat, input logic [7:0] edat, input logic chk, input logic eerr);
        exp_t e;
        @(negedge clk);
        cyc_type = ct;
        we   = (ct == CT_WRMEM) || (ct == CT_WRIO);
        adr  = a_adr;
        wdat = a_dat;
        lock = a_lock;
        cyc  = 1'b1;
        stb  = 1'b1;
        if (push) begin
            e.name = name; e.dat = edat; e.chk_dat = chk; e.err = eerr; e.due = cyc_cnt + lat;
            q.push_back(e);
        end
    endtask

    task automatic wait_ack(input string name);
        int i = 0;
        while (!(ack_o || err_o) && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!(ack_o || err_o)) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no ack/err within 40 cycles", name);
        end
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; lock = 1'b0; cyc_type = CT_PASSIVE;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, b1;
        repeat (3) @(negedge clk);
        check("rst_dat", {24'd0, dat_o}, 32'hFF);
        check("rst_strobes", {27'd0, ack_o, err_o, mem_ce_o, mem_we_o, io_stb_o}, 32'd0);
        check("rst_flags", {29'd0, inta_o, halted_o, locked_o}, 32'd0);
        check("rst_mem_adr", mem_adr_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SRAM read, RD_LAT=2: ack in cycle 4
        issue("code_rd", CT_CODE, BASE + 32'd5, 8'h00, 1'b0, 1'b1, 4, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check("code_rd_ce", {31'd0, mem_ce_o}, 32'd1);
        check("code_rd_adr", mem_adr_o, 32'd5);
        wait_ack("code_rd");
        release_bus();

        // SRAM write with strobe held past ack
        b0 = we_cnt; b1 = ack_cnt;
        issue("wr", CT_WRMEM, BASE + 32'd1, 8'h3C, 1'b0, 1'b1, 2, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("wr_we", {31'd0, mem_we_o}, 32'd1);
        check("wr_dat", {24'd0, mem_dat_o}, 32'h3C);
        wait_ack("wr");
        repeat (3) @(negedge clk);
        release_bus();
        check("wr_we_pulses", we_cnt - b0, 32'd1);
        check("wr_acks", ack_cnt - b1, 32'd1);
        issue("rd_back", CT_RDMEM, BASE + 32'd1, 8'h00, 1'b0, 1'b1, 4, 8'h3C, 1'b1, 1'b0);
        wait_ack("rd_back");
        release_bus();

        // I/O read, io_ack_i three cycles late
        b0 = io_cnt;
        issue("io_rd", CT_RDIO, 32'h0000_0060, 8'h00, 1'b0, 1'b1, 5, 8'h1E, 1'b1, 1'b0);
        @(negedge clk);
        check("io_rd_adr", {16'd0, io_adr_o}, 32'h0060);
        check("io_rd_we", {31'd0, io_we_o}, 32'd0);
        repeat (3) @(negedge clk);
        io_ack_i = 1'b1; io_dat_i = 8'h1E;
        @(negedge clk);
        io_ack_i = 1'b0;
        wait_ack("io_rd");
        release_bus();
        check("io_rd_stb_cycles", io_cnt - b0, 32'd4);

        // I/O write acked in the cycle the strobe rises
        issue("io_wr", CT_WRIO, 32'hABCD_1234, 8'h55, 1'b0, 1'b1, 2, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        io_ack_i = 1'b1;
        check("io_wr_adr", {16'd0, io_adr_o}, 32'h1234);
        check("io_wr_dat", {24'd0, io_dat_o}, 32'h55);
        @(negedge clk);
        io_ack_i = 1'b0;
        wait_ack("io_wr");
        release_bus();

        // Locked INTA, then HALT until the next CODE cycle
        b0 = inta_cnt;
        int_vect = 8'h08;
        issue("inta", CT_INTA, 32'd0, 8'h00, 1'b1, 1'b1, 1, 8'h08, 1'b1, 1'b0);
        wait_ack("inta");
        check("inta_pulse", {31'd0, inta_o}, 32'd1);
        check("inta_locked", {31'd0, locked_o}, 32'd1);
        release_bus();
        check("unlock", {31'd0, locked_o}, 32'd0);
        check("inta_pulses", inta_cnt - b0, 32'd1);
        issue("halt", CT_HALT, 32'd0, 8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0);
        wait_ack("halt");
        release_bus();
        repeat (3) @(negedge clk);
        check("halted_set", {31'd0, halted_o}, 32'd1);
        issue("code_after_halt", CT_CODE, BASE + 32'd1, 8'h00, 1'b0, 1'b1, 4, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        check("halted_clr", {31'd0, halted_o}, 32'd0);
        wait_ack("code_after_halt");
        release_bus();

        // Window boundaries
        b0 = ce_cnt; b1 = we_cnt;
        issue("last_byte", CT_RDMEM, BASE + SIZE - 32'd1, 8'h00, 1'b0, 1'b1, 4, 8'h77, 1'b1, 1'b0);
        wait_ack("last_byte");
        release_bus();
        issue("oow_hi", CT_RDMEM, BASE + SIZE, 8'h00, 1'b0, 1'b1, 1, OOW_DAT, 1'b1, OOW_ERR);
        wait_ack("oow_hi");
        release_bus();
        issue("oow_lo", CT_CODE, BASE - 32'd1, 8'h00, 1'b0, 1'b1, 1, OOW_DAT, 1'b1, OOW_ERR);
        wait_ack("oow_lo");
        release_bus();
        issue("oow_wr", CT_WRMEM, BASE + SIZE, 8'h99, 1'b0, 1'b1, 1, 8'h00, 1'b0, OOW_ERR);
        wait_ack("oow_wr");
        release_bus();
        check("oow_ce_count", ce_cnt - b0, 32'd1);
        check("oow_we_count", we_cnt - b1, 32'd0);

        // Abort in MEM_RD, then reset during IO
        b0 = ack_cnt;
        issue("abort_rd", CT_CODE, BASE + 32'd5, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_rd_no_ack", ack_cnt - b0, 32'd0);
        issue("rst_io", CT_RDIO, 32'h0000_0061, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; lock = 1'b0; io_ack_i = 1'b1; io_dat_i = 8'h42;
        #1;
        check("rst_io_stb", {31'd0, io_stb_o}, 32'd0);
        check("rst_io_dat", {24'd0, dat_o}, 32'hFF);
        check("rst_io_locked", {31'd0, locked_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; io_ack_i = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_io_no_ack", ack_cnt - b0, 32'd0);
        issue("rd_after_rst", CT_CODE, BASE + 32'd5, 8'h00, 1'b0, 1'b1, 4, 8'hA5, 1'b1, 1'b0);
        wait_ack("rd_after_rst");
        release_bus();

        check("pending_acks", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
